arp_cache_table: RTL and testbench

// - Parametrised ARP cache: DEPTH-entry IP->MAC table with learn, lookup, flush and replacement.
// - Sits between the ARP RX parser (learn side) and the IP TX header builder (lookup side).
// - Also registers the local MAC/IP configuration for the rest of the stack.

---
 rtl/arp_cache_table.sv | 221 ++++++++++++++++++++++
 tb/tb_arp_cache_table.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_cache_table.sv
// arp_cache_table: DEPTH-entry IP->MAC cache with learn, scanned lookup, flush, RR replacement.
// Optional per-entry aging is enabled by defining ARP_CACHE_AGING_EN.
module arp_cache_table #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AGE_W    = 8,
    parameter int unsigned MAX_AGE  = 200,
    parameter int unsigned TICK_DIV = 125000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [47:0]             mac_config_addr_in,
    input  logic [31:0]             ip_config_addr_in,
    output logic [47:0]             mac_config_addr_out,
    output logic [31:0]             ip_config_addr_out,
    input  logic [31:0]             learn_ip,
    input  logic [47:0]             learn_mac,
    input  logic                    learn_valid,
    input  logic [31:0]             lookup_ip,
    input  logic                    lookup_valid,
    output logic                    lookup_ready,
    output logic                    lookup_done,
    output logic                    lookup_hit,
    output logic [47:0]             lookup_mac,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  entry_count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [31:0]      lat_ip;
    logic [DEPTH-1:0] valid;
    logic [31:0]      ip_tab  [DEPTH];
    logic [47:0]      mac_tab [DEPTH];

    logic             learn_ok;
    logic             match_any;
    logic             free_any;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [DEPTH-1:0] expire;
    logic [DEPTH-1:0] valid_n;
    logic [CNT_W-1:0] count_n;
    logic             bypass;
    logic             scan_end;
    logic             scan_res_hit;
    logic [47:0]      scan_res_mac;
    logic             fast_hit;
    logic [47:0]      fast_mac;

    assign learn_ok = learn_valid && !flush && (learn_ip != '0)
                      && (learn_ip != ip_config_addr_in) && !learn_mac[40];

    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && ip_tab[i] == learn_ip) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign wr_idx = match_any ? match_idx : (free_any ? free_idx : rr_ptr);

    always_comb begin
        valid_n = flush ? '0 : (valid & ~expire);
        if (learn_ok)
            valid_n[wr_idx] = 1'b1;
        count_n = '0;
        for (int i = 0; i < DEPTH; i++)
            count_n = count_n + CNT_W'(valid_n[i]);
    end

    assign bypass   = learn_ok && (learn_ip == lat_ip);
    assign fast_hit = (lookup_ip == '1) || (lookup_ip == ip_config_addr_in);
    assign fast_mac = (lookup_ip == '1) ? '1 : mac_config_addr_in;

    // flush beats a same-cycle learn bypass, which beats the table compare
    always_comb begin
        scan_end     = 1'b0;
        scan_res_hit = 1'b0;
        scan_res_mac = '0;
        if (flush) begin
            scan_end = 1'b1;
        end else if (bypass) begin
            scan_end     = 1'b1;
            scan_res_hit = 1'b1;
            scan_res_mac = learn_mac;
        end else if (expire[scan_idx]) begin
            scan_end = 1'b1;
        end else if (valid[scan_idx] && ip_tab[scan_idx] == lat_ip) begin
            scan_end     = 1'b1;
            scan_res_hit = 1'b1;
            scan_res_mac = mac_tab[scan_idx];
        end else if (scan_idx == IDX_W'(DEPTH - 1)) begin
            scan_end = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (learn_ok) begin
            ip_tab[wr_idx]  <= learn_ip;
            mac_tab[wr_idx] <= learn_mac;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state               <= IDLE;
            scan_idx            <= '0;
            rr_ptr              <= '0;
            lat_ip              <= '0;
            valid               <= '0;
            entry_count         <= '0;
            mac_config_addr_out <= '0;
            ip_config_addr_out  <= '0;
            lookup_ready        <= 1'b0;
            lookup_done         <= 1'b0;
            lookup_hit          <= 1'b0;
            lookup_mac          <= '0;
        end else begin
            mac_config_addr_out <= mac_config_addr_in;
            ip_config_addr_out  <= ip_config_addr_in;
            valid               <= valid_n;
            entry_count         <= count_n;
            if (learn_ok && !match_any && !free_any)
                rr_ptr <= rr_ptr + 1'b1;

            lookup_done <= 1'b0;
            lookup_hit  <= 1'b0;
            lookup_mac  <= '0;
            unique case (state)
                IDLE: begin
                    if (lookup_valid && lookup_ready) begin
                        lat_ip       <= lookup_ip;
                        scan_idx     <= '0;
                        lookup_ready <= 1'b0;
                        if (fast_hit) begin
                            state       <= RESP;
                            lookup_done <= 1'b1;
                            lookup_hit  <= 1'b1;
                            lookup_mac  <= fast_mac;
                        end else begin
                            state <= SCAN;
                        end
                    end else begin
                        lookup_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_end) begin
                        state       <= RESP;
                        lookup_done <= 1'b1;
                        lookup_hit  <= scan_res_hit;
                        lookup_mac  <= scan_res_mac;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    lookup_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARP_CACHE_AGING_EN
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [AGE_W-1:0]  age [DEPTH];

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // a learn that targets an entry keeps it alive even on its expiry tick
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            expire[i] = tick && valid[i] && (age[i] == AGE_W'(MAX_AGE - 1))
                        && !(learn_ok && wr_idx == IDX_W'(i));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tick_cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                age[i] <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (learn_ok && wr_idx == IDX_W'(i))
                    age[i] <= '0;
                else if (tick && valid[i])
                    age[i] <= age[i] + 1'b1;
            end
        end
    end
`else
    assign expire = '0;

    // aging parameters have no effect here; keep them referenced
    if (AGE_W == 0 || MAX_AGE == 0 || TICK_DIV == 0) begin : g_aging_params_unused
    end
`endif

endmodule

// File: tb/tb_arp_cache_table.sv
// tb_arp_cache_table: directed self-checking bench for arp_cache_table (DEPTH=4).
// Aging scenarios run when ARP_CACHE_AGING_EN is defined.
module tb_arp_cache_table;
    localparam logic [47:0] CFG_MAC = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [31:0] CFG_IP  = 32'h0A00_0064;
    localparam logic [31:0] IP1  = 32'h0A00_0001;
    localparam logic [31:0] IP2  = 32'h0A00_0002;
    localparam logic [31:0] IP3  = 32'h0A00_0003;
    localparam logic [31:0] IP4  = 32'h0A00_0004;
    localparam logic [31:0] IP5  = 32'h0A00_0005;
    localparam logic [31:0] IP7  = 32'h0A00_0007;
    localparam logic [31:0] IP8  = 32'h0A00_0008;
    localparam logic [31:0] IP9  = 32'h0A00_0009;
    localparam logic [31:0] IP77 = 32'h0A00_004D;
    localparam logic [31:0] IP99 = 32'h0A00_0063;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [47:0] mac_config_addr_in;
    logic [31:0] ip_config_addr_in;
    logic [47:0] mac_config_addr_out;
    logic [31:0] ip_config_addr_out;
    logic [31:0] learn_ip;
    logic [47:0] learn_mac;
    logic        learn_valid;
    logic [31:0] lookup_ip;
    logic        lookup_valid;
    logic        lookup_ready;
    logic        lookup_done;
    logic        lookup_hit;
    logic [47:0] lookup_mac;
    logic        flush;
    logic [2:0]  entry_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat;
    logic rdy_seen;

    arp_cache_table #(
        .DEPTH(4), .AGE_W(8), .MAX_AGE(3), .TICK_DIV(4)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .mac_config_addr_in(mac_config_addr_in),
        .ip_config_addr_in(ip_config_addr_in),
        .mac_config_addr_out(mac_config_addr_out),
        .ip_config_addr_out(ip_config_addr_out),
        .learn_ip(learn_ip),
        .learn_mac(learn_mac),
        .learn_valid(learn_valid),
        .lookup_ip(lookup_ip),
        .lookup_valid(lookup_valid),
        .lookup_ready(lookup_ready),
        .lookup_done(lookup_done),
        .lookup_hit(lookup_hit),
        .lookup_mac(lookup_mac),
        .flush(flush),
        .entry_count(entry_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        learn_ip    = ip;
        learn_mac   = mac;
        learn_valid = 1'b1;
        step();
        learn_valid = 1'b0;
    endtask

    task automatic start_lookup(input logic [31:0] ip);
        int w = 0;
        while (!lookup_ready && w < 20) begin
            step();
            w++;
        end
        lookup_ip    = ip;
        lookup_valid = 1'b1;
        step();
        lookup_valid = 1'b0;
    endtask

    // latency counts edges from the accept edge to the edge that samples done
    task automatic wait_done(output int l);
        l = 1;
        rdy_seen = lookup_ready;
        while (!lookup_done && l < 40) begin
            step();
            l++;
            rdy_seen = rdy_seen | lookup_ready;
        end
    endtask

    task automatic do_lookup(input logic [31:0] ip, output int l);
        start_lookup(ip);
        wait_done(l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn            = 1'b0;
        mac_config_addr_in = CFG_MAC;
        ip_config_addr_in  = CFG_IP;
        learn_ip           = '0;
        learn_mac          = '0;
        learn_valid        = 1'b0;
        lookup_ip          = '0;
        lookup_valid       = 1'b0;
        flush              = 1'b0;

        repeat (3) step();
        check("rst_ready", lookup_ready, 0);
        check("rst_done", lookup_done, 0);
        check("rst_count", entry_count, 0);
        check("rst_cfg_mac", mac_config_addr_out, 0);
        aresetn = 1'b1;
        step();
        check("rel_ready", lookup_ready, 1);
        check("cfg_mac", mac_config_addr_out, CFG_MAC);
        check("cfg_ip", ip_config_addr_out, CFG_IP);

`ifdef ARP_CACHE_AGING_EN
        learn(IP1, 48'h02_00_00_00_00_01);
        check("age_learn_cnt", entry_count, 1);
        repeat (8) step();
        check("age_alive8", entry_count, 1);
        repeat (4) step();
        check("age_expired12", entry_count, 0);

        learn(IP2, 48'h02_00_00_00_00_02);
        for (int r = 0; r < 4; r++) begin
            repeat (7) step();
            learn(IP2, 48'h02_00_00_00_00_02);
            check("age_refresh_cnt", entry_count, 1);
        end
        do_lookup(IP2, lat);
        check("age_refresh_lat", lat, 2);
        check("age_refresh_hit", lookup_hit, 1);
`else
        learn(IP1, 48'h02_00_00_00_00_01);
        check("learn1_cnt", entry_count, 1);
        do_lookup(IP1, lat);
        check("hit1_lat", lat, 2);
        check("hit1_hit", lookup_hit, 1);
        check("hit1_mac", lookup_mac, 48'h02_00_00_00_00_01);
        step();
        check("hit1_done_pulse", lookup_done, 0);

        do_lookup(IP9, lat);
        check("miss9_lat", lat, 5);
        check("miss9_hit", lookup_hit, 0);
        check("miss9_mac", lookup_mac, 0);
        check("miss9_ready_low", rdy_seen, 0);

        learn(32'h0, 48'h02_00_00_00_00_11);
        learn(CFG_IP, 48'h02_00_00_00_00_12);
        learn(IP7, 48'h01_00_5E_00_00_01);
        check("filter_cnt", entry_count, 1);
        do_lookup(IP7, lat);
        check("filter_mc_miss", lookup_hit, 0);

        learn(IP2, 48'h02_00_00_00_00_02);
        learn(IP3, 48'h02_00_00_00_00_03);
        learn(IP4, 48'h02_00_00_00_00_04);
        check("full_cnt", entry_count, 4);
        learn(IP5, 48'h02_00_00_00_00_05);
        check("replace_cnt", entry_count, 4);
        do_lookup(IP1, lat);
        check("replaced1_hit", lookup_hit, 0);
        check("replaced1_lat", lat, 5);
        do_lookup(IP5, lat);
        check("new5_hit", lookup_hit, 1);
        check("new5_lat", lat, 2);
        check("new5_mac", lookup_mac, 48'h02_00_00_00_00_05);

        learn(IP2, 48'h02_00_00_00_00_22);
        check("update_cnt", entry_count, 4);
        do_lookup(IP2, lat);
        check("update_lat", lat, 3);
        check("update_mac", lookup_mac, 48'h02_00_00_00_00_22);

        do_lookup(32'hFFFF_FFFF, lat);
        check("bcast_lat", lat, 1);
        check("bcast_hit", lookup_hit, 1);
        check("bcast_mac", lookup_mac, 48'hFFFF_FFFF_FFFF);
        do_lookup(CFG_IP, lat);
        check("local_lat", lat, 1);
        check("local_mac", lookup_mac, CFG_MAC);

        start_lookup(IP8);
        learn_ip    = IP8;
        learn_mac   = 48'h02_00_00_00_00_88;
        learn_valid = 1'b1;
        step();
        learn_valid = 1'b0;
        check("bypass_done", lookup_done, 1);
        check("bypass_hit", lookup_hit, 1);
        check("bypass_mac", lookup_mac, 48'h02_00_00_00_00_88);
        step();
        check("bypass_cnt", entry_count, 4);
        do_lookup(IP8, lat);
        check("bypass_stored_lat", lat, 3);
        check("bypass_stored_mac", lookup_mac, 48'h02_00_00_00_00_88);
        do_lookup(IP2, lat);
        check("rr_second_victim", lookup_hit, 0);

        start_lookup(IP99);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_done", lookup_done, 1);
        check("flush_hit", lookup_hit, 0);
        check("flush_mac", lookup_mac, 0);
        check("flush_cnt", entry_count, 0);

        flush       = 1'b1;
        learn(IP3, 48'h02_00_00_00_00_03);
        flush       = 1'b0;
        check("flush_learn_cnt", entry_count, 0);
        do_lookup(IP3, lat);
        check("flush_learn_miss", lookup_hit, 0);

        learn(IP1, 48'h02_00_00_00_00_01);
        check("pre_rst_cnt", entry_count, 1);
        start_lookup(IP77);
        step();
        aresetn = 1'b0;
        step();
        check("midrst_ready", lookup_ready, 0);
        check("midrst_done", lookup_done, 0);
        step();
        check("midrst_ready2", lookup_ready, 0);
        aresetn = 1'b1;
        step();
        check("postrst_ready", lookup_ready, 1);
        check("postrst_cnt", entry_count, 0);
        do_lookup(IP1, lat);
        check("postrst_miss", lookup_hit, 0);
        check("postrst_lat", lat, 5);

        learn(IP4, 48'h02_00_00_00_00_44);
        repeat (40) step();
        check("persist_cnt", entry_count, 1);
        do_lookup(IP4, lat);
        check("persist_hit", lookup_hit, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
